s_ram_n: RTL and testbench
==========================

Name: s_ram_n

Overview:
- Parametrised WIDTH x DEPTH word-addressable register memory with synchronous write and registered read.
- Built from the multi-bit gate library's demux/mux selection idea, widened to any power-of-two depth.
- Adds a hardware clear sweep FSM that zeroes every word after reset or on request, with a busy flag.
- Sits as the generic RAM building block (RAM8/RAM64-class) under the CPU datapath and register files.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- DEPTH, 8, number of words; power of two, >=2.
- ADDR_W, 3, address width; must equal log2(DEPTH). Elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  write data.
- address  input  ADDR_W  read/write word address.
- load  input  1  write enable for the addressed word.
- clear  input  1  one-cycle request to start a clear sweep.
- out  output  WIDTH  registered read data.
- busy  output  1  high while a clear sweep is in progress.

Behaviour:
- Reset is one clock, synchronous, active-high: all state changes on the rising edge of clk, and reset is sampled only there.
- Reset cycle effects: out<=0, busy<=1, state<=CLEAR, sweep pointer ptr<=0. The memory array is not reset directly; the sweep zeroes it.
- FSM states: IDLE and CLEAR.
- CLEAR, each cycle with reset low:
  - mem[ptr]<=0 and ptr<=ptr+1.
  - When ptr==DEPTH-1, that word is written, then state<=IDLE and busy<=0.
  - busy is therefore high for exactly DEPTH cycles after reset deasserts.
- CLEAR, other rules:
  - out is held at 0 throughout.
  - load and clear are ignored.
- IDLE, clear=1:
  - state<=CLEAR, ptr<=0, busy<=1 on the next edge.
  - load in the same cycle is dropped, because clear has priority.
  - out<=0 on that edge.
- IDLE, load=1 (clear=0): mem[address]<=in on the edge.
- IDLE read:
  - out<=mem[address] every cycle, giving 1-cycle latency.
  - There is no read enable; out tracks the previous cycle's address.
- Read-during-write to the same address in IDLE is governed by the optional feature below.
- Reset mid-sweep restarts the sweep: ptr<=0, and busy stays 1 for DEPTH further cycles after release.
- Address wrap: ADDR_W bits exactly cover DEPTH, so there are no out-of-range addresses. ptr wraps from DEPTH-1 only at sweep end.
- No X on out after the first reset edge. Before the first reset, out is unspecified.

Optional Feature:
- Macro: S_RAM_N_BYPASS_EN.
- Defined: a load and a read to the same address in the same IDLE cycle give out<=in (write-first, new data visible at 1-cycle latency).
- Undefined: the same case gives out<=old mem[address] (read-first); the new value is visible on the following cycle.
- Writes themselves are identical in both builds.

Test Plan:
- Assert reset 1 cycle, then release -> busy=1 for exactly 8 cycles, then 0; out=0 throughout; a subsequent read of every address 0..7 returns 16'h0000.
- After the sweep, load=1, address=3, in=16'hBEEF; next cycle load=0, address=3 -> out=16'hBEEF one cycle later; a read of address 7 still returns 16'h0000.
- Write 16'h1234 to address 5, then load=1, address=5, in=16'hABCD with reads at address 5:
  - with S_RAM_N_BYPASS_EN: out=16'hABCD after 1 cycle.
  - without it: out=16'h1234 after 1 cycle, then 16'hABCD on the next.
- Fill addresses 0..7 with 16'hFFFF, pulse clear=1 together with load=1, address=2, in=16'h5555 -> busy=1 for 8 cycles, the load is dropped, and all words read 16'h0000 afterwards.
- During a sweep, drive load=1, address=0, in=16'hAAAA -> ignored; address 0 reads 16'h0000 after busy falls.
- Assert reset at sweep cycle 4 -> busy stays 1 for 8 full cycles after release; all words read 16'h0000.

Source files
------------

// File: rtl/s_ram_n.sv
// s_ram_n: WIDTH x DEPTH word-addressable register memory.
//   Synchronous write, registered read (1-cycle latency), and a hardware clear
//   sweep that zeroes one word per cycle after reset or on a clear request.
//   Optional macro S_RAM_N_BYPASS_EN: write-first read-during-write
//   (default build is read-first).

// One storage word; the top-level demux drives its enable and data.
module s_ram_n_word #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // Storage register, deliberately unreset: the sweep clears it.
  always_ff @(posedge clk) begin
    if (we) q <= d;
  end
endmodule

module s_ram_n #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);
  generate
    if (DEPTH < 2 || ADDR_W != $clog2(DEPTH) || (1 << ADDR_W) != DEPTH) begin : g_bad_cfg
      $error("s_ram_n: DEPTH must be a power of two >= 2 and ADDR_W == log2(DEPTH)");
    end
  endgenerate

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                       state;
  logic [ADDR_W-1:0]            ptr;
  logic [DEPTH-1:0][WIDTH-1:0]  words;
  logic [DEPTH-1:0]             we;
  logic [ADDR_W-1:0]            wr_addr;
  logic [WIDTH-1:0]             wr_data;
  logic                         wr_en;

  // Write-port arbitration: the sweep owns the port in CLEAR; a load only
  // lands in IDLE when no clear request competes with it.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = address;
    wr_data = in;
    if (!reset) begin
      if (state == CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = ptr;
        wr_data = '0;
      end else if (load && !clear) begin
        wr_en   = 1'b1;
      end
    end
  end

  // Address demux into the per-word enables, one storage cell per word.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
      assign we[i] = wr_en && (wr_addr == ADDR_W'(i));
      s_ram_n_word #(.WIDTH(WIDTH)) u_word (
        .clk (clk),
        .we  (we[i]),
        .d   (wr_data),
        .q   (words[i])
      );
    end
  endgenerate

  // Sweep FSM and registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
      busy  <= 1'b1;
      out   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          out <= '0;
          ptr <= ptr + ADDR_W'(1);
          if (ptr == ADDR_W'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          if (clear) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
            out   <= '0;
          end else begin
`ifdef S_RAM_N_BYPASS_EN
            out <= load ? in : words[address];
`else
            out <= words[address];
`endif
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_s_ram_n.sv
// Self-checking bench for s_ram_n: a behavioural model (remaining-sweep count
// plus a plain word array) is checked against the DUT every cycle, alongside
// directed literal checks that follow the test plan.
module tb_s_ram_n;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [WIDTH-1:0]  in = '0;
  logic [ADDR_W-1:0] address = '0;
  logic              load = 1'b0;
  logic              clear = 1'b0;
  logic [WIDTH-1:0]  out;
  logic              busy;

  int pass_cnt = 0;
  int total = 0;

  s_ram_n #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .in(in), .address(address),
    .load(load), .clear(clear), .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: sweep_left counts remaining sweep cycles; the memory
  // becomes all-zero when a sweep completes (it is unobservable during one).
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic [WIDTH-1:0] m_out;
  int               sweep_left = 0;
  bit               m_valid = 0;

  always @(posedge clk) begin
    logic [WIDTH-1:0] old;
    if (reset) begin
      sweep_left = DEPTH;
      m_out      = '0;
      m_valid    = 1;
    end else if (sweep_left > 0) begin
      sweep_left = sweep_left - 1;
      m_out      = '0;
      if (sweep_left == 0)
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else if (clear) begin
      sweep_left = DEPTH;
      m_out      = '0;
    end else begin
      old = m_mem[address];
      if (load) m_mem[address] = in;
`ifdef S_RAM_N_BYPASS_EN
      m_out = load ? in : old;
`else
      m_out = old;
`endif
    end
  end

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      total++;
      if (out === m_out) pass_cnt++;
      else $display("FAIL model_out t=%0t got=%h want=%h", $time, out, m_out);
      total++;
      if (busy === (sweep_left > 0)) pass_cnt++;
      else $display("FAIL model_busy t=%0t got=%b want=%b", $time, busy, sweep_left > 0);
    end
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s got=%h want=%h", name, act, exp);
  endtask

  task automatic step(input logic l, input logic c, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    load = l; clear = c; address = a; in = d;
    @(posedge clk); #1;
  endtask

  // Counts cycles with busy high, stepping with the given load attempt.
  task automatic count_busy(input logic l, input logic [WIDTH-1:0] d, output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      step(l, 1'b0, '0, d);
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, '0, '0);
    reset = 1'b0;
  endtask

  task automatic read_all_zero(input string name);
    for (int a = 0; a < DEPTH; a++) begin
      step(1'b0, 1'b0, ADDR_W'(a), '0);
      check(name, out, 16'h0000);
    end
  endtask

  initial begin
    int n;
    @(posedge clk); #1;
    do_reset();
    check("reset_out", out, 16'h0000);
    check("reset_busy", {15'b0, busy}, 16'h0001);
    count_busy(1'b0, '0, n);
    check("sweep_len_after_reset", 16'(n), 16'd8);
    read_all_zero("post_reset_read");

    step(1'b1, 1'b0, 3'd3, 16'hBEEF);
    step(1'b0, 1'b0, 3'd3, 16'h0);
    check("read_beef", out, 16'hBEEF);
    step(1'b0, 1'b0, 3'd7, 16'h0);
    check("read_7_zero", out, 16'h0000);

    step(1'b1, 1'b0, 3'd5, 16'h1234);
    step(1'b1, 1'b0, 3'd5, 16'hABCD);
`ifdef S_RAM_N_BYPASS_EN
    check("rdw_same_cycle", out, 16'hABCD);
`else
    check("rdw_same_cycle", out, 16'h1234);
`endif
    step(1'b0, 1'b0, 3'd5, 16'h0);
    check("rdw_next_cycle", out, 16'hABCD);

    for (int a = 0; a < DEPTH; a++) step(1'b1, 1'b0, ADDR_W'(a), 16'hFFFF);
    step(1'b0, 1'b0, 3'd6, 16'h0);
    check("fill_ffff", out, 16'hFFFF);
    step(1'b1, 1'b1, 3'd2, 16'h5555);
    check("clear_busy", {15'b0, busy}, 16'h0001);
    check("clear_out", out, 16'h0000);
    count_busy(1'b1, 16'hAAAA, n);
    check("sweep_len_after_clear", 16'(n), 16'd8);
    read_all_zero("post_clear_read");

    step(1'b0, 1'b1, '0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0);
    do_reset();
    count_busy(1'b0, '0, n);
    check("sweep_len_midreset", 16'(n), 16'd8);
    read_all_zero("post_midreset_read");

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      step($urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0,
           ADDR_W'($urandom_range(0, DEPTH - 1)), WIDTH'($urandom));
    end
    reset = 1'b0;
    step(1'b0, 1'b0, '0, '0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
